// File: rtl/sb_tx_packet_framer_q_if.sv
// Sideband TX framer bus bundle.
//   Encoder side : i_pkt_valid, o_pkt_ready, i_header, i_data, i_has_data
//   Serializer   : i_ser_done, o_phase, o_phase_valid, o_timeout_ctr_start
// Signal names carry the framer's point of view (i_ = into the framer).
// Modports: slave = the framer, master = encoder/serializer side (or a bench).
interface sb_tx_packet_framer_q_if #(
    parameter int PHASE_W = 64
);
    logic               i_pkt_valid;
    logic               o_pkt_ready;
    logic [PHASE_W-3:0] i_header;
    logic [PHASE_W-1:0] i_data;
    logic               i_has_data;
    logic               i_ser_done;
    logic [PHASE_W-1:0] o_phase;
    logic               o_phase_valid;
    logic               o_timeout_ctr_start;

    modport slave (
        input  i_pkt_valid, i_header, i_data, i_has_data, i_ser_done,
        output o_pkt_ready, o_phase, o_phase_valid, o_timeout_ctr_start
    );

    modport master (
        output i_pkt_valid, i_header, i_data, i_has_data, i_ser_done,
        input  o_pkt_ready, o_phase, o_phase_valid, o_timeout_ctr_start
    );
endinterface

// File: rtl/sb_tx_packet_framer_q.sv
// sb_tx_packet_framer_q
// Sideband TX packet framer with a DEPTH-entry packet queue. Packets from the
// message encoder are queued together with their control parity (cp = ^header)
// and data parity (dp = has_data ? ^data : 0), then sent to the serializer as a
// 64b header phase {dp, cp, header} followed by an optional data phase.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   bus (slave)          packet input handshake + serializer phase output
//   i_perr_inj           (only with SB_TX_FRAMER_PERR_INJ_EN) invert cp of the
//                        header phase registered in this cycle
//   o_fifo_count         queued packets including the one in flight
//   o_busy               FSM not in IDLE
//
// Optional feature macro: SB_TX_FRAMER_PERR_INJ_EN.
//
// Phase outputs are registered on the edge that leaves the issuing state, so
// the state sequence seen while o_phase_valid is high is:
//   IDLE --(header registered)--> HDR -> GAP -> WAIT_D --(data registered)--> IDLE_GAP -> IDLE
//   IDLE --(header registered, no data)--> HDR -> IDLE_GAP -> IDLE
// HDR, GAP and IDLE_GAP are single cycles that ignore i_ser_done, which gives
// the serializer time to drop i_ser_done after each phase and keeps the data
// phase at least 3 cycles behind its header phase.
module sb_tx_packet_framer_q #(
    parameter int PHASE_W     = 64,
    parameter int DEPTH       = 4,
    parameter int OPC_LSB     = 14,
    parameter int OPC_W       = 4,
    parameter int TIMEOUT_OPC = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    sb_tx_packet_framer_q_if.slave     bus,
`ifdef SB_TX_FRAMER_PERR_INJ_EN
    input  logic                       i_perr_inj,
`endif
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
    output logic                       o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_GAP, S_WAIT_D, S_IDLE_GAP
    } state_t;

    // queue storage (contents need no reset; pointers/count do)
    logic [PHASE_W-3:0] r_hdr [DEPTH];
    logic [PHASE_W-1:0] r_dat [DEPTH];
    logic               r_hd  [DEPTH];
    logic               r_cp  [DEPTH];
    logic               r_dp  [DEPTH];

    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    state_t             r_state, w_next;
    logic               r_cur_hd;      // has_data of the packet in flight
    logic [PHASE_W-1:0] r_phase;
    logic               r_phase_valid, r_to_start;

    logic w_push, w_pop, w_emit_hdr, w_emit_dat, w_cp_inj, w_to_hit;

`ifdef SB_TX_FRAMER_PERR_INJ_EN
    assign w_cp_inj = i_perr_inj;
`else
    assign w_cp_inj = 1'b0;
`endif

    // ready from registered count only: a full queue refuses an offer even
    // when the same edge pops an entry
    assign bus.o_pkt_ready = (r_count != CW'(DEPTH));
    assign w_push          = bus.i_pkt_valid && bus.o_pkt_ready;
    assign w_to_hit        = (r_hdr[r_rd_ptr][OPC_LSB +: OPC_W] == OPC_W'(TIMEOUT_OPC));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_hdr[r_wr_ptr] <= bus.i_header;
            r_dat[r_wr_ptr] <= bus.i_data;
            r_hd[r_wr_ptr]  <= bus.i_has_data;
            r_cp[r_wr_ptr]  <= ^bus.i_header;
            r_dp[r_wr_ptr]  <= bus.i_has_data ? ^bus.i_data : 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_emit_hdr = 1'b0;
        w_emit_dat = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0 && bus.i_ser_done) begin
                    w_emit_hdr = 1'b1;
                    // header-only packet is complete once its header goes out
                    w_pop      = !r_hd[r_rd_ptr];
                    w_next     = S_HDR;
                end
            end
            S_HDR:      w_next = r_cur_hd ? S_GAP : S_IDLE_GAP;
            S_GAP:      w_next = S_WAIT_D;
            S_WAIT_D: begin
                if (bus.i_ser_done) begin
                    w_emit_dat = 1'b1;
                    w_pop      = 1'b1;
                    w_next     = S_IDLE_GAP;
                end
            end
            S_IDLE_GAP: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_to_start    <= 1'b0;
            r_cur_hd      <= 1'b0;
        end else begin
            r_phase_valid <= w_emit_hdr || w_emit_dat;
            r_to_start    <= w_emit_hdr && w_to_hit;
            if (w_emit_hdr) begin
                r_phase  <= {r_dp[r_rd_ptr], r_cp[r_rd_ptr] ^ w_cp_inj, r_hdr[r_rd_ptr]};
                r_cur_hd <= r_hd[r_rd_ptr];
            end else if (w_emit_dat) begin
                r_phase  <= r_dat[r_rd_ptr];
            end
        end
    end

    assign bus.o_phase             = r_phase;
    assign bus.o_phase_valid       = r_phase_valid;
    assign bus.o_timeout_ctr_start = r_to_start;
    assign o_fifo_count            = r_count;
    assign o_busy                  = (r_state != S_IDLE);
endmodule

// File: tb/tb_sb_tx_packet_framer_q.sv
// Scoreboard bench for sb_tx_packet_framer_q: the driver pushes the expected
// phases of every accepted packet into a queue; a negedge monitor pops and
// compares whenever o_phase_valid is seen, and tracks the expected queue count.
module tb_sb_tx_packet_framer_q;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] ph;
        logic        to;
        int          kind;   // 0 header-only, 1 header with data, 2 data
        logic        last;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       perr_inj = 1'b0;
    logic [2:0] o_fifo_count;
    logic       o_busy;

    int total = 0, bad = 0;
    int n_acc = 0, n_done = 0;
    int cyc = 0, hdr_cyc = 0;
    logic prev_v = 1'b0;
    logic rnd_done;
    exp_t sb[$];

    sb_tx_packet_framer_q_if #(.PHASE_W(64)) vif();

    sb_tx_packet_framer_q #(.DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .bus          (vif),
`ifdef SB_TX_FRAMER_PERR_INJ_EN
        .i_perr_inj   (perr_inj),
`endif
        .o_fifo_count (o_fifo_count),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Offer one packet from a negedge; returns at a negedge with valid low.
    task automatic push(input logic [61:0] h, input logic [63:0] d, input logic hd,
                        output int waited);
        logic acc;
        exp_t e;
        vif.i_pkt_valid = 1'b1;
        vif.i_header    = h;
        vif.i_data      = d;
        vif.i_has_data  = hd;
        waited = 0;
        forever begin
            acc = vif.o_pkt_ready;
            @(posedge i_clk);
            if (acc) break;
            waited++;
            if (waited > 300) break;
            @(negedge i_clk);
        end
        if (waited > 300) begin
            chk("push_timeout", 64'(waited), 0);
        end else begin
            n_acc++;
            e.ph   = {(hd ? ^d : 1'b0), ^h, h};
            e.to   = (h[17:14] == 4'd5);
            e.kind = hd ? 1 : 0;
            e.last = !hd;
            sb.push_back(e);
            if (hd) begin
                e.ph = d; e.to = 1'b0; e.kind = 2; e.last = 1'b1;
                sb.push_back(e);
            end
        end
        @(negedge i_clk);
        vif.i_pkt_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while ((sb.size() != 0 || n_acc != n_done) && k < bound) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain_left", 64'(sb.size()), 0);
        repeat (3) @(negedge i_clk);
        chk("idle_after_drain", 64'(o_busy), 0);
    endtask

    function automatic logic [61:0] rnd_hdr();
        logic [61:0] h;
        h = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) h[17:14] = 4'd5;
        return h;
    endfunction

    // monitor / scoreboard
    always @(negedge i_clk) begin
        exp_t e;
        logic [63:0] ep;
        cyc++;
        if (!i_rst_n) begin
            prev_v = 1'b0;
            chk("rst_phase", vif.o_phase, 64'd0);
            chk("rst_ctl", 64'({o_busy, vif.o_phase_valid, vif.o_timeout_ctr_start,
                                vif.o_pkt_ready, o_fifo_count}), 64'({4'b0001, 3'd0}));
        end else begin
            if (vif.o_phase_valid) begin
                chk("valid_b2b", 64'(prev_v), 0);
                if (sb.size() == 0) begin
                    chk("spurious_phase", 64'(vif.o_phase_valid), 0);
                end else begin
                    e  = sb.pop_front();
                    ep = e.ph;
`ifdef SB_TX_FRAMER_PERR_INJ_EN
                    if (e.kind != 2) ep[62] = ep[62] ^ perr_inj;
`endif
                    chk("phase", vif.o_phase, ep);
                    chk("timeout_start", 64'(vif.o_timeout_ctr_start), 64'(e.to));
                    if (e.kind == 1) hdr_cyc = cyc;
                    if (e.kind == 2) chk("data_gap_ge3", 64'((cyc - hdr_cyc) >= 3), 1);
                    if (e.last) n_done++;
                end
            end else if (vif.o_timeout_ctr_start) begin
                chk("timeout_without_valid", 64'(vif.o_timeout_ctr_start), 0);
            end
            chk("fifo_count", 64'(o_fifo_count), 64'(n_acc - n_done));
            prev_v = vif.o_phase_valid;
        end
    end

    initial begin
        int w;
        vif.i_pkt_valid = 1'b0;
        vif.i_header    = '0;
        vif.i_data      = '0;
        vif.i_has_data  = 1'b0;
        vif.i_ser_done  = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 1: header-only packet, latency and single pulse
        vif.i_ser_done = 1'b1;
        push(62'h1, 64'h0, 1'b0, w);
        chk("t1_no_valid_yet", 64'(vif.o_phase_valid), 0);
        chk("t1_count_1", 64'(o_fifo_count), 1);
        @(negedge i_clk);
        chk("t1_valid", 64'(vif.o_phase_valid), 1);
        chk("t1_phase", vif.o_phase, 64'h4000_0000_0000_0001);
        chk("t1_count_0", 64'(o_fifo_count), 0);
        @(negedge i_clk);
        chk("t1_single_pulse", 64'(vif.o_phase_valid), 0);
        wait_drain(50);

        // 2: timeout opcode with data phase
        push(62'h5 << 14, 64'h3, 1'b1, w);
        wait_drain(50);

        // 3: fill with serializer stalled, refuse extra offer, drain in order
        vif.i_ser_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(rnd_hdr(), {$urandom, $urandom}, 1'(i), w);
        chk("t3_not_ready", 64'(vif.o_pkt_ready), 0);
        chk("t3_count_full", 64'(o_fifo_count), DEPTH);
        vif.i_pkt_valid = 1'b1;
        vif.i_header    = 62'h3;
        vif.i_has_data  = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        vif.i_pkt_valid = 1'b0;
        chk("t3_extra_refused", 64'(o_fifo_count), DEPTH);
        vif.i_ser_done = 1'b1;
        wait_drain(200);

        // 4: offer into full queue on the pop edge, then wrap pointers
        vif.i_ser_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(rnd_hdr(), 64'h0, 1'b0, w);
        vif.i_ser_done = 1'b1;
        push(rnd_hdr(), {$urandom, $urandom}, 1'b1, w);
        chk("t4_waited_one", 64'(w), 1);
        for (int i = 0; i < 3 * DEPTH; i++)
            push(rnd_hdr(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), w);
        wait_drain(400);

        // random traffic with a wobbling serializer
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge i_clk);
                    push(rnd_hdr(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge i_clk);
                    vif.i_ser_done = ($urandom_range(0, 3) != 0);
                end
            end
        join
        vif.i_ser_done = 1'b1;
        wait_drain(1000);

        // 5: reset between header and data phase
        push(rnd_hdr(), 64'hDEAD_BEEF_0000_0001, 1'b1, w);
        for (int k = 0; k < 50 && !vif.o_phase_valid; k++) @(negedge i_clk);
        chk("t5_header_seen", 64'(vif.o_phase_valid), 1);
        #2;
        i_rst_n = 1'b0;
        sb.delete();
        n_acc  = 0;
        n_done = 0;
        @(negedge i_clk);
        chk("t5_rst_count", 64'(o_fifo_count), 0);
        chk("t5_rst_valid", 64'(vif.o_phase_valid), 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        chk("t5_idle_after_release", 64'(o_busy), 0);

`ifdef SB_TX_FRAMER_PERR_INJ_EN
        // 6: cp inverted at header issue
        perr_inj = 1'b1;
        push(62'h1, 64'h0, 1'b0, w);
        @(negedge i_clk);
        chk("t6_cp_inverted", 64'(vif.o_phase[62]), 0);
        @(negedge i_clk);
        perr_inj = 1'b0;
        wait_drain(50);
`endif

        chk("sb_empty_end", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
